// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor (a - b - bin) built from two half subtractors,
// the borrow-chain counterpart of the full-adder cell.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
  half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one bit per clock with a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q;
  logic [WIDTH-1:0] ra_q, rb_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, busy_q, done_q, borrow_out_q;
  logic             bit_d, borrow_d;

  full_subtractor u_fs (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (borrow_d)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ra_q     <= a;
            rb_q     <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_q   <= {bit_d, diff_q[WIDTH-1:1]};
          ra_q     <= ra_q >> 1;
          rb_q     <= rb_q >> 1;
          borrow_q <= borrow_d;
          // Counter parks at zero on the last bit so it never reaches WIDTH.
          if (cnt_q == LAST) begin
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            borrow_out_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= (ra_q[0] ^ rb_q[0]) & (bit_d ^ ra_q[0]);
`endif
            state_q      <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
// Build with SERIAL_SUB_OVF_EN defined to also check the ovf output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
  logic         ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  // Reference model: plain modular arithmetic on the operands.
  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sd;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
    return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
  endfunction

  // Drives one operation and reports the number of edges from acceptance to done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] od, output logic ob, output logic oo,
                       output int lat, output bit timeout);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin timeout = 1'b0; break; end
    end
    od = diff; ob = borrow_out; oo = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if ({busy, done, borrow_out, ovf} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, borrow_out, ovf}); else pass_cnt++;
    total_cnt++; if (diff !== '0) $display("FAIL reset_diff got %h want 00", diff); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb, input bit chk_lat);
    logic [W-1:0] od; logic ob, oo; int lat; bit to;
    do_op(ta, tb, od, ob, oo, lat, to);
    total_cnt++; if (to) $display("FAIL %s timeout waiting for done", nm); else pass_cnt++;
    total_cnt++; if (od !== m_diff(ta, tb)) $display("FAIL %s diff %h-%h got %h want %h", nm, ta, tb, od, m_diff(ta, tb)); else pass_cnt++;
    total_cnt++; if (ob !== m_borrow(ta, tb)) $display("FAIL %s borrow %h-%h got %b want %b", nm, ta, tb, ob, m_borrow(ta, tb)); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total_cnt++; if (oo !== m_ovf(ta, tb)) $display("FAIL %s ovf %h-%h got %b want %b", nm, ta, tb, oo, m_ovf(ta, tb)); else pass_cnt++;
`endif
    if (chk_lat) begin
      total_cnt++; if (lat !== W) $display("FAIL %s latency got %0d want %0d", nm, lat, W); else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL %s done_width got %b want 0", nm, done); else pass_cnt++;
  endtask

  task automatic test_directed();
    run_check("d5m3", 8'd5, 8'd3, 1'b1);
    total_cnt++; if (diff !== 8'h02) $display("FAIL d5m3_const got %h want 02", diff); else pass_cnt++;
    run_check("d3m5", 8'd3, 8'd5, 1'b1);
    total_cnt++; if ({borrow_out, diff} !== 9'h1FE) $display("FAIL d3m5_const got %h want 1fe", {borrow_out, diff}); else pass_cnt++;
    run_check("d0m1", 8'd0, 8'd1, 1'b1);
    run_check("dffmff", 8'hFF, 8'hFF, 1'b1);
    run_check("daam55", 8'hAA, 8'h55, 1'b1);
    total_cnt++; if ({borrow_out, diff} !== 9'h055) $display("FAIL daam55_const got %h want 055", {borrow_out, diff}); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_check("rand", W'($urandom), W'($urandom), 1'b0);
  endtask

  task automatic test_ignore_start();
    int lat; bit to, busy_ok;
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    busy_ok = busy;
    repeat (3) begin @(posedge clk); @(negedge clk); busy_ok &= busy; end
    a = 8'h77; b = 8'h01; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0; busy_ok &= busy;
    total_cnt++; if (!busy_ok) $display("FAIL ignore_busy got 0 want 1"); else pass_cnt++;
    lat = 4; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; lat++;
      if (done) begin to = 1'b0; break; end
    end
    total_cnt++; if (to || lat != W) $display("FAIL ignore_latency got %0d want %0d", lat, W); else pass_cnt++;
    total_cnt++; if ({borrow_out, diff} !== {m_borrow(8'h12, 8'h34), m_diff(8'h12, 8'h34)})
      $display("FAIL ignore_result got %h want %h", {borrow_out, diff}, {m_borrow(8'h12, 8'h34), m_diff(8'h12, 8'h34)}); else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL ignore_not_queued busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    @(negedge clk);
    a = 8'h40; b = 8'h41; start = 1'b1;
    @(posedge clk); #1;
    n = 0; first = -1; second = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1; n++;
      if (done && first < 0) first = n;
      else if (done && first >= 0) begin second = n; break; end
    end
    start = 1'b0;
    total_cnt++; if (first != W) $display("FAIL b2b_first got %0d want %0d", first, W); else pass_cnt++;
    total_cnt++; if (second != 2 * (W + 2) - 2) $display("FAIL b2b_second got %0d want %0d", second, 2 * (W + 2) - 2); else pass_cnt++;
    total_cnt++; if ({borrow_out, diff} !== 9'h1FF) $display("FAIL b2b_result got %h want 1ff", {borrow_out, diff}); else pass_cnt++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    @(negedge clk);
    a = 8'hC3; b = 8'h0F; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, done, borrow_out, ovf, diff} !== '0)
      $display("FAIL midrst_outputs got %h want 0", {busy, done, borrow_out, ovf, diff}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin @(posedge clk); #1; saw_done |= done; end
    total_cnt++; if (saw_done) $display("FAIL midrst_no_done got 1 want 0"); else pass_cnt++;
    run_check("midrst_after", 8'hC3, 8'h0F, 1'b1);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    run_check("ovf80m01", 8'h80, 8'h01, 1'b0);
    total_cnt++; if ({ovf, diff} !== 9'h17F) $display("FAIL ovf80m01_const got %h want 17f", {ovf, diff}); else pass_cnt++;
    run_check("ovf10m01", 8'h10, 8'h01, 1'b0);
    total_cnt++; if ({ovf, diff} !== 9'h00F) $display("FAIL ovf10m01_const got %h want 00f", {ovf, diff}); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
